vga_digit_sched: RTL and testbench

VGA_DIGIT_SCHED -- requirements
Module: vga_digit_sched

---
 rtl/vga_digit_pkg.sv | 40 ++++
 rtl/vga_digit_encode.sv | 35 +++
 rtl/vga_digit_sched.sv | 147 ++++++++++++++
 tb/tb_vga_digit_sched.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_digit_pkg.sv
// vga_digit_pkg: shared constants and types for the VGA digit scheduler.
//   - Cell geometry (four 32x64 cells on a 40-pixel pitch starting at 256,208)
//   - Special digit codes (DASH_CODE, BLANK_CODE)
//   - Frame-boundary line, theme encodings, write-FSM states, settings struct
// Optional feature macro used by the including files: VGA_DIGIT_BLINK_EN.
package vga_digit_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [9:0] CELL_X0    = 10'd256;
  localparam logic [9:0] CELL_PITCH = 10'd40;
  localparam logic [9:0] CELL_W     = 10'd32;
  localparam logic [9:0] CELL_Y0    = 10'd208;
  localparam logic [9:0] CELL_H     = 10'd64;

  localparam logic [9:0] FRAME_LINE = 10'd480;

  localparam logic [3:0] DASH_CODE  = 4'd10;
  localparam logic [3:0] BLANK_CODE = 4'd11;

  typedef enum logic [1:0] {
    THEME_0 = 2'd0,
    THEME_1 = 2'd1,
    THEME_2 = 2'd2,
    THEME_3 = 2'd3
  } theme_e;

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } wr_state_e;

  // One complete display setting; shadow and active copies share this type.
  typedef struct packed {
    logic [15:0] value;
    theme_e      theme;
    logic        lzb;
  } disp_cfg_t;

endpackage

// File: rtl/vga_digit_encode.sv
// vga_digit_encode: combinational mapping of four BCD nibbles to digit codes.
// Ports:
//   value_i [15:0]  four BCD digits, [15:12] is digit 0 (most significant)
//   lzb_i           leading-zero blanking enable (digit 3 is never blanked)
//   blink_i [3:0]   per-digit blank request (already gated by the blink phase)
//   code_o  [3:0]   code_o[k] is the code for digit k: 0-9, DASH_CODE, BLANK_CODE
// Optional feature macro in the system: VGA_DIGIT_BLINK_EN (handled by the top).
module vga_digit_encode
  import vga_digit_pkg::*;
(
  input  logic [15:0]     value_i,
  input  logic            lzb_i,
  input  logic [3:0]      blink_i,
  output logic [3:0][3:0] code_o
);

  logic       lead_zero;
  logic [3:0] nib;

  always_comb begin
    code_o    = '0;
    nib       = '0;
    // Stays set only while every digit seen so far is a literal zero;
    // a dash (10-15) clears it like any other non-zero digit.
    lead_zero = lzb_i;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      nib       = value_i[4*(NUM_DIGITS-1-k) +: 4];
      lead_zero = lead_zero && (nib == 4'd0);
      code_o[k] = (nib > 4'd9) ? DASH_CODE : nib;
      if (lead_zero && (k < NUM_DIGITS - 1)) code_o[k] = BLANK_CODE;
      if (blink_i[k])                        code_o[k] = BLANK_CODE;
    end
  end

endmodule

// File: rtl/vga_digit_sched.sv
// vga_digit_sched: schedules a 4-digit BCD display onto a VGA raster.
// Updates are accepted through a valid/ready handshake into shadow registers
// and committed to the displayed (active) registers at the next frame
// boundary (v_cnt=480, h_cnt=0), so a frame never shows a torn value.
// Ports:
//   clk, rst_n            pixel clock, asynchronous active-low reset
//   h_cnt, v_cnt [9:0]    current pixel column / line
//   wr_valid, wr_ready    update handshake (ready only while nothing pending)
//   wr_value [15:0]       BCD digits, [15:12] = digit 0
//   wr_theme [1:0], wr_lzb requested theme and leading-zero blanking
//   blink_mask [3:0]      per-digit blink select
//   num [3:0]             digit code for the pixel seen one clock earlier
//   theme [1:0]           committed theme
//   digit_active, loc_x [4:0], loc_y [5:0]  in-cell flag and in-cell offset
// Config macro: VGA_DIGIT_BLINK_EN adds a 5-bit frame counter; digits with
// blink_mask[k]=1 are blanked while its MSB is set. Without it blink_mask
// is ignored.
module vga_digit_sched
  import vga_digit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [15:0] wr_value,
  input  logic [1:0]  wr_theme,
  input  logic        wr_lzb,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  num,
  output logic [1:0]  theme,
  output logic        digit_active,
  output logic [4:0]  loc_x,
  output logic [5:0]  loc_y
);

  wr_state_e       state_q, state_d;
  disp_cfg_t       shadow_q, shadow_d;
  disp_cfg_t       active_q, active_d;

  logic [3:0]      num_q, num_d;
  logic            hit_q, hit_d;
  logic [4:0]      lx_q, lx_d;
  logic [5:0]      ly_q, ly_d;

  logic            frame_boundary;
  logic [3:0]      blink;
  logic [3:0][3:0] codes;
  logic [9:0]      base;
  logic            y_in;

  assign frame_boundary = (v_cnt == FRAME_LINE) && (h_cnt == '0);

`ifdef VGA_DIGIT_BLINK_EN
  logic [4:0] frame_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              frame_q <= '0;
    else if (frame_boundary) frame_q <= frame_q + 5'd1;
  end

  assign blink = blink_mask & {4{frame_q[4]}};
`else
  logic unused_blink_mask;
  assign unused_blink_mask = ^blink_mask;
  assign blink             = '0;
`endif

  vga_digit_encode u_encode (
    .value_i (active_q.value),
    .lzb_i   (active_q.lzb),
    .blink_i (blink),
    .code_o  (codes)
  );

  // Write FSM. A commit only happens from PENDING, so an accept on the
  // boundary cycle waits for the following boundary.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    wr_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          shadow_d = '{value: wr_value, theme: theme_e'(wr_theme), lzb: wr_lzb};
          state_d  = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (frame_boundary) begin
          active_d = shadow_q;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pixel-to-cell mapping; cells never overlap, so at most one k matches.
  always_comb begin
    hit_d = 1'b0;
    lx_d  = '0;
    ly_d  = '0;
    num_d = BLANK_CODE;
    base  = CELL_X0;
    y_in  = (v_cnt >= CELL_Y0) && (v_cnt < CELL_Y0 + CELL_H);
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      base = CELL_X0 + 10'(k) * CELL_PITCH;
      if (y_in && (h_cnt >= base) && (h_cnt < base + CELL_W)) begin
        hit_d = 1'b1;
        lx_d  = 5'(h_cnt - base);
        ly_d  = 6'(v_cnt - CELL_Y0);
        num_d = codes[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      shadow_q <= '0;
      active_q <= '0;
      num_q    <= BLANK_CODE;
      hit_q    <= 1'b0;
      lx_q     <= '0;
      ly_q     <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      num_q    <= num_d;
      hit_q    <= hit_d;
      lx_q     <= lx_d;
      ly_q     <= ly_d;
    end
  end

  assign num          = num_q;
  assign theme        = active_q.theme;
  assign digit_active = hit_q;
  assign loc_x        = lx_q;
  assign loc_y        = ly_q;

endmodule

// File: tb/tb_vga_digit_sched.sv
module tb_vga_digit_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  h_cnt = '0;
  logic [9:0]  v_cnt = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] wr_value = '0;
  logic [1:0]  wr_theme = '0;
  logic        wr_lzb = 1'b0;
  logic [3:0]  blink_mask = '0;
  logic [3:0]  num;
  logic [1:0]  theme;
  logic        digit_active;
  logic [4:0]  loc_x;
  logic [5:0]  loc_y;

  vga_digit_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .h_cnt        (h_cnt),
    .v_cnt        (v_cnt),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_value     (wr_value),
    .wr_theme     (wr_theme),
    .wr_lzb       (wr_lzb),
    .blink_mask   (blink_mask),
    .num          (num),
    .theme        (theme),
    .digit_active (digit_active),
    .loc_x        (loc_x),
    .loc_y        (loc_y)
  );

  always #5 clk = ~clk;

  typedef struct {
    int num;
    int theme;
    int act;
    int lx;
    int ly;
    int rdy;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: what is displayed, what is waiting, frame count.
  int   m_val = 0, m_theme = 0, m_lzb = 0;
  int   s_val = 0, s_theme = 0, s_lzb = 0;
  bit   m_pend = 0;
  int   m_frame = 0;

  function automatic int exp_code(int k, int blinkm);
    int d;
    d = (m_val >> (4 * (3 - k))) & 15;
`ifdef VGA_DIGIT_BLINK_EN
    if (m_frame >= 16 && ((blinkm >> k) & 1) == 1) return 11;
`endif
    // Digits 0..k all zero means the value shifted down to digit k is zero.
    if (m_lzb != 0 && k < 3 && (m_val >> (4 * (3 - k))) == 0) return 11;
    return (d > 9) ? 10 : d;
  endfunction

  task automatic chk(string name, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic step(int x, int y, bit v, int val, int th, bit lz, bit rst);
    exp_t e;
    int   k;
    int   bm;
    @(negedge clk);
    rst_n      = rst;
    h_cnt      = 10'(x);
    v_cnt      = 10'(y);
    wr_valid   = v;
    wr_value   = 16'(val);
    wr_theme   = 2'(th);
    wr_lzb     = lz;
    bm         = int'($urandom_range(0, 15));
    blink_mask = 4'(bm);
    if (!rst) begin
      m_val = 0; m_theme = 0; m_lzb = 0;
      s_val = 0; s_theme = 0; s_lzb = 0;
      m_pend = 0; m_frame = 0;
      e = '{11, 0, 0, 0, 0, 1};
    end else begin
      e = '{11, 0, 0, 0, 0, 1};
      if (y >= 208 && y < 272 && x >= 256 && x < 416 && (x - 256) % 40 < 32) begin
        k     = (x - 256) / 40;
        e.act = 1;
        e.lx  = (x - 256) % 40;
        e.ly  = y - 208;
        e.num = exp_code(k, bm);
      end
      if (m_pend) begin
        if (x == 0 && y == 480) begin
          m_val = s_val; m_theme = s_theme; m_lzb = s_lzb;
          m_pend = 0;
        end
      end else if (v) begin
        s_val = val; s_theme = th; s_lzb = lz;
        m_pend = 1;
      end
      if (x == 0 && y == 480) m_frame = (m_frame + 1) % 32;
      e.theme = m_theme;
      e.rdy   = m_pend ? 0 : 1;
    end
    q.push_back(e);
  endtask

  task automatic pix(int x, int y);
    step(x, y, 1'b0, 0, 0, 1'b0, 1'b1);
  endtask

  task automatic wr(int val, int th, bit lz);
    step(50, 50, 1'b1, val, th, lz, 1'b1);
  endtask

  task automatic boundary();
    pix(0, 480);
  endtask

  task automatic scan();
    for (int k = 0; k < 4; k++) pix(256 + 40 * k + 3 + k, 215 + k);
    pix(288, 208);
    pix(415, 271);
    pix(416, 271);
    pix(256, 272);
  endtask

  // Monitor: every driven cycle produces one registered output set.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("num", int'(num), e.num);
      chk("theme", int'(theme), e.theme);
      chk("digit_active", int'(digit_active), e.act);
      chk("loc_x", int'(loc_x), e.lx);
      chk("loc_y", int'(loc_y), e.ly);
      chk("wr_ready", int'(wr_ready), e.rdy);
    end
  end

  initial begin
    int x, y, val;
    repeat (3) step(100, 100, 1'b0, 0, 0, 1'b0, 1'b0);
    pix(256, 208);

    wr('h1234, 2, 1'b0);
    repeat (3) pix(300, 210);
    boundary();
    pix(300, 210);
    scan();

    wr('h0050, 1, 1'b1);
    boundary();
    scan();
    wr('h0000, 3, 1'b1);
    boundary();
    scan();
    wr('h0A07, 0, 1'b1);
    boundary();
    scan();

    // Accept on the boundary cycle, then a dropped second request.
    step(0, 480, 1'b1, 'h9876, 1, 1'b0, 1'b1);
    pix(300, 210);
    step(10, 10, 1'b1, 'h1111, 2, 1'b1, 1'b1);
    scan();
    boundary();
    scan();

    // Reset while pending discards the update.
    wr('h4321, 3, 1'b0);
    repeat (2) step(300, 210, 1'b0, 0, 0, 1'b0, 1'b0);
    scan();
    boundary();
    scan();

    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        x = 0; y = 480;
      end else if ($urandom_range(0, 9) == 0) begin
        x = int'($urandom_range(0, 799)); y = int'($urandom_range(0, 524));
      end else begin
        x = int'($urandom_range(240, 430)); y = int'($urandom_range(200, 280));
      end
      val = int'($urandom_range(0, 65535)) >> $urandom_range(0, 14);
      step(x, y, ($urandom_range(0, 7) == 0), val,
           int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1);
    end

    pix(10, 10);
    @(negedge clk);
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
